iir_feedback: RTL and testbench



---
 rtl/iir_feedback.sv | 147 ++++++++++++++
 tb/tb_iir_feedback.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/iir_feedback.sv
// iir_feedback: recursive section of a direct-form-I IIR stage.
// y[n] = x[n] - sum a[k]*y[n-1-k], rounded half-up and saturated.
module iir_feedback #(
  parameter int OUTPUT_TAPS      = 2,
  parameter int DATA_WIDTH       = 24,
  parameter int COEFF_WIDTH      = 18,
  parameter int DATA_FRAC_WIDTH  = 0,
  parameter int COEFF_FRAC_WIDTH = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic signed [DATA_WIDTH-1:0]  x_i,
  input  logic                          valid_i,
  output logic                          ready_and_o,
  input  logic signed [COEFF_WIDTH-1:0] coeff_y_i [0:OUTPUT_TAPS-1],
  output logic signed [DATA_WIDTH-1:0]  y_o,
  output logic                          valid_o,
  input  logic                          ready_and_i
);

  localparam int FW = DATA_FRAC_WIDTH + COEFF_FRAC_WIDTH;
  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int AW = PW + $clog2(OUTPUT_TAPS + 1) + 1;
  localparam int HW = AW - DATA_WIDTH + 1;
  localparam logic [AW-1:0] RND = (AW'(1) << FW) >> 1;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    ACC,
    STORE
  } state_t;

  state_t state;
  state_t next_state;

  logic accept;
  logic do_mult;
  logic do_acc;
  logic do_store;
  logic drain;

  logic signed [DATA_WIDTH-1:0]  x_reg;
  logic signed [COEFF_WIDTH-1:0] coeff [0:OUTPUT_TAPS-1];
  logic signed [DATA_WIDTH-1:0]  ytap  [0:OUTPUT_TAPS-1];
  logic signed [PW-1:0]          prod  [0:OUTPUT_TAPS-1];
  logic signed [AW-1:0]          acc;

  logic signed [AW-1:0]         sum;
  logic signed [AW-1:0]         rnd_sum;
  logic signed [AW-1:0]         shifted;
  logic [HW-1:0]                hi;
  logic                         ovf;
  logic signed [DATA_WIDTH-1:0] y_sat;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      ready_and_o <= 1'b0;
    end else begin
      state       <= next_state;
      ready_and_o <= (next_state == IDLE);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (valid_i && ready_and_o) next_state = MULT;
      MULT:  next_state = ACC;
      ACC:   if (!valid_o) next_state = STORE;
      STORE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == IDLE) && valid_i && ready_and_o;
    do_mult  = (state == MULT);
    do_acc   = (state == ACC);
    do_store = (state == STORE);
    drain    = valid_o && ready_and_i;
  end

  always_comb begin
    sum = AW'(x_reg) <<< COEFF_FRAC_WIDTH;
    for (int k = 0; k < OUTPUT_TAPS; k++) begin
      sum = sum - AW'(prod[k]);
    end
  end

  // Round half toward +inf, then clamp to the data range.
  always_comb begin
    rnd_sum = acc + $signed(RND);
    shifted = rnd_sum >>> FW;
    hi      = shifted[AW-1:DATA_WIDTH-1];
    ovf     = !((&hi) || !(|hi));
    if (ovf) begin
      y_sat = shifted[AW-1] ?
        {1'b1, {(DATA_WIDTH-1){1'b0}}} :
        {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      y_sat = shifted[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      x_reg   <= '0;
      acc     <= '0;
      y_o     <= '0;
      valid_o <= 1'b0;
      for (int k = 0; k < OUTPUT_TAPS; k++) begin
        coeff[k] <= '0;
        ytap[k]  <= '0;
        prod[k]  <= '0;
      end
    end else begin
      if (accept) begin
        x_reg <= x_i;
        for (int k = 0; k < OUTPUT_TAPS; k++) begin
          coeff[k] <= coeff_y_i[k];
        end
      end
      if (do_mult) begin
        for (int k = 0; k < OUTPUT_TAPS; k++) begin
          prod[k] <= PW'(coeff[k]) * PW'(ytap[k]);
        end
      end
      if (do_acc) begin
        acc <= sum;
      end
      if (drain) begin
        valid_o <= 1'b0;
      end
      if (do_store) begin
        ytap[0] <= y_sat;
        for (int k = 1; k < OUTPUT_TAPS; k++) begin
          ytap[k] <= ytap[k-1];
        end
        y_o     <= y_sat;
        valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iir_feedback.sv
// tb_iir_feedback: directed vectors for iir_feedback.
// Impulse, pass-through, saturation, backpressure, reset, coeff latch.
module tb_iir_feedback;

  logic               clk = 1'b0;
  logic               rst_i;
  logic signed [23:0] x_i;
  logic               valid_i;
  logic               ready_and_o;
  logic signed [17:0] coeff [0:1];
  logic signed [23:0] y_o;
  logic               valid_o;
  logic               ready_and_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iir_feedback dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .x_i         (x_i),
    .valid_i     (valid_i),
    .ready_and_o (ready_and_o),
    .coeff_y_i   (coeff),
    .y_o         (y_o),
    .valid_o     (valid_o),
    .ready_and_i (ready_and_i)
  );

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
  endtask

  task automatic send(input int x);
    int n = 0;
    while (!ready_and_o && n < 50) begin
      step();
      n++;
    end
    if (!ready_and_o) chk("send_tmo", 0, 1);
    x_i     = 24'(x);
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    t_acc   = cyc;
  endtask

  task automatic get(output int y, output int lat);
    int n = 0;
    while (!valid_o && n < 50) begin
      step();
      n++;
    end
    if (!valid_o) chk("get_tmo", 0, 1);
    y   = y_o;
    lat = cyc - t_acc;
  endtask

  task automatic impulse(input string pfx);
    int xs [5] = '{1000, 0, 0, 0, 0};
    int ys [5] = '{1000, 500, 250, 125, 63};
    int y;
    int lat;
    for (int i = 0; i < 5; i++) begin
      send(xs[i]);
      get(y, lat);
      chk($sformatf("%s_y%0d", pfx, i), y, ys[i]);
      chk($sformatf("%s_lat%0d", pfx, i), lat, 3);
    end
  endtask

  initial begin
    int y;
    int lat;
    int pt [3] = '{8388607, -8388608, -1};

    rst_i       = 1'b0;
    valid_i     = 1'b0;
    ready_and_i = 1'b1;
    x_i         = '0;
    coeff[0]    = '0;
    coeff[1]    = '0;
    step();
    step();
    chk("rst_ready", ready_and_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_y", y_o, 0);
    rst_i = 1'b1;
    step();
    chk("rel_ready", ready_and_o, 1);

    coeff[0] = -18'sd16384;
    impulse("imp");

    coeff[0] = '0;
    for (int i = 0; i < 3; i++) begin
      send(pt[i]);
      chk($sformatf("pt_rdy%0d_0", i), ready_and_o, 0);
      step();
      chk($sformatf("pt_rdy%0d_1", i), ready_and_o, 0);
      step();
      chk($sformatf("pt_rdy%0d_2", i), ready_and_o, 0);
      step();
      chk($sformatf("pt_rdy%0d_3", i), ready_and_o, 1);
      chk($sformatf("pt_vld%0d", i), valid_o, 1);
      chk($sformatf("pt_y%0d", i), y_o, pt[i]);
    end

    do_reset();
    coeff[0] = -18'sd32767;
    for (int i = 0; i < 4; i++) begin
      send(8388607);
      get(y, lat);
      chk($sformatf("satp_y%0d", i), y, 8388607);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(-8388608);
      get(y, lat);
      chk($sformatf("satn_y%0d", i), y, -8388608);
    end

    do_reset();
    coeff[0] = -18'sd16384;
    send(1000);
    get(y, lat);
    chk("bp_y0", y, 1000);
    ready_and_i = 1'b0;
    send(0);
    for (int i = 0; i < 10; i++) step();
    chk("bp_hold_vld", valid_o, 1);
    chk("bp_hold_y", y_o, 1000);
    chk("bp_hold_rdy", ready_and_o, 0);
    ready_and_i = 1'b1;
    step();
    chk("bp_drop", valid_o, 0);
    step();
    chk("bp_acc2st", valid_o, 0);
    step();
    chk("bp_vld2", valid_o, 1);
    chk("bp_y2", y_o, 500);

    send(1000);
    rst_i = 1'b0;
    step();
    chk("mr_y", y_o, 0);
    chk("mr_vld", valid_o, 0);
    chk("mr_rdy", ready_and_o, 0);
    rst_i = 1'b1;
    step();
    chk("mr_rel", ready_and_o, 1);
    impulse("mr");

    do_reset();
    coeff[0] = -18'sd16384;
    send(1000);
    get(y, lat);
    chk("cl_y0", y, 1000);
    send(0);
    coeff[0] = '0;
    step();
    coeff[0] = 18'sd5000;
    get(y, lat);
    chk("cl_y1", y, 500);
    coeff[0] = '0;
    send(0);
    get(y, lat);
    chk("cl_y2", y, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
